// File: rtl/game_flow_controller.sv
// Game sequencer for the Bomber Man VGA game: state machine, lives, score and level countdown.
// Consumes per-frame hit/kill pulses; drives freeze/respawn controls and display values.
//
// state        | meaning
// IDLE (0)     | waiting for start key, play frozen
// PLAY (1)     | normal play, timer running, kills scored
// DYING (2)    | player hit, invulnerable, respawn countdown in frames
// LEVEL_CLR (3)| bonus tally of remaining seconds, then start key for next level
// GAME_OVER (4)| final score/lives held until start key
module game_flow_controller #(
   parameter int LIVES_INIT     = 3,
   parameter int FRAMES_PER_SEC = 30,
   parameter int LEVEL_TIME_SEC = 180,
   parameter int RESPAWN_FRAMES = 60,
   parameter int SCORE_PER_KILL = 100,
   parameter int BONUS_PER_SEC  = 10,
   parameter int SCORE_MAX      = 9999
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        start_key,
   input  logic        player_hit,
   input  logic        enemy_kill,
   input  logic [3:0]  enemies_left,
   output logic [2:0]  game_state,
   output logic [1:0]  lives,
   output logic [13:0] score,
   output logic [7:0]  time_left,
   output logic        freeze_play,
   output logic        respawn_pulse
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PLAY      = 3'd1;
   localparam logic [2:0] S_DYING     = 3'd2;
   localparam logic [2:0] S_LEVEL_CLR = 3'd3;
   localparam logic [2:0] S_GAME_OVER = 3'd4;

   localparam int FCW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_SEC - 1);

   logic [2:0]     state_nx;
   logic [1:0]     lives_nx;
   logic [13:0]    score_nx;
   logic [7:0]     time_nx;
   logic [FCW-1:0] frame_cnt, frame_nx;
   logic [7:0]     dying_cnt, dying_nx;
   logic           freeze_nx, respawn_nx;
   logic           start_key_d, start_edge;
   logic           sec_tick, timeout, dying_done;
   logic [14:0]    kill_sum, bonus_sum;
   logic [13:0]    kill_sat, bonus_sat;

   assign start_edge = start_key & ~start_key_d;
   assign sec_tick   = startOfFrame && (frame_cnt == FRAME_LAST);
   assign timeout    = sec_tick && (time_left == 8'd1);
   assign dying_done = startOfFrame && (({1'b0, dying_cnt} + 9'd1) == 9'(RESPAWN_FRAMES));

   // Sums are one bit wider than score so the clamp sees the true result.
   assign kill_sum  = {1'b0, score} + 15'(SCORE_PER_KILL);
   assign bonus_sum = {1'b0, score} + 15'(BONUS_PER_SEC);
   assign kill_sat  = (kill_sum  > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : kill_sum[13:0];
   assign bonus_sat = (bonus_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : bonus_sum[13:0];

   always_ff @(posedge clk) begin
      if (!resetN) begin
         game_state    <= S_IDLE;
         lives         <= '0;
         score         <= '0;
         time_left     <= '0;
         frame_cnt     <= '0;
         dying_cnt     <= '0;
         start_key_d   <= 1'b0;
         freeze_play   <= 1'b1;
         respawn_pulse <= 1'b0;
      end else begin
         game_state    <= state_nx;
         lives         <= lives_nx;
         score         <= score_nx;
         time_left     <= time_nx;
         frame_cnt     <= frame_nx;
         dying_cnt     <= dying_nx;
         start_key_d   <= start_key;
         freeze_play   <= freeze_nx;
         respawn_pulse <= respawn_nx;
      end
   end

   always_comb begin
      state_nx = game_state;
      case (game_state)
         S_IDLE:      if (start_edge) state_nx = S_PLAY;
         S_PLAY: begin
            if (player_hit)              state_nx = S_DYING;
            else if (timeout)            state_nx = S_GAME_OVER;
            else if (enemies_left == '0) state_nx = S_LEVEL_CLR;
         end
         S_DYING:     if (dying_done) state_nx = (lives == '0) ? S_GAME_OVER : S_PLAY;
         S_LEVEL_CLR: if (time_left == '0 && start_edge) state_nx = S_PLAY;
         S_GAME_OVER: if (start_edge) state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      lives_nx   = lives;
      score_nx   = score;
      time_nx    = time_left;
      frame_nx   = frame_cnt;
      dying_nx   = dying_cnt;
      freeze_nx  = (state_nx != S_PLAY);
      respawn_nx = (state_nx == S_PLAY) && (game_state != S_PLAY);
      case (game_state)
         S_IDLE: begin
            if (start_edge) begin
               lives_nx = 2'(LIVES_INIT);
               score_nx = '0;
               time_nx  = 8'(LEVEL_TIME_SEC);
               frame_nx = '0;
            end
         end
         S_PLAY: begin
            if (enemy_kill) score_nx = kill_sat;
            if (player_hit) begin
               lives_nx = (lives == '0) ? 2'd0 : lives - 2'd1;
               dying_nx = '0;
            end else begin
               if (startOfFrame) begin
                  if (sec_tick) begin
                     frame_nx = '0;
                     if (time_left != '0) time_nx = time_left - 8'd1;
                  end else begin
                     frame_nx = frame_cnt + 1'b1;
                  end
               end
               if (!timeout && enemies_left == '0) frame_nx = '0;
            end
         end
         S_DYING: begin
            if (startOfFrame && dying_cnt != 8'hFF) dying_nx = dying_cnt + 8'd1;
         end
         S_LEVEL_CLR: begin
            // Start key only counts once the tally has drained the clock.
            if (time_left != '0) begin
               if (startOfFrame) begin
                  time_nx  = time_left - 8'd1;
                  score_nx = bonus_sat;
               end
            end else if (start_edge) begin
               time_nx  = 8'(LEVEL_TIME_SEC);
               frame_nx = '0;
            end
         end
         S_GAME_OVER: begin
            if (start_edge) begin
               lives_nx = '0;
               score_nx = '0;
               time_nx  = '0;
            end
         end
         default: begin
            lives_nx = '0;
            score_nx = '0;
            time_nx  = '0;
            frame_nx = '0;
            dying_nx = '0;
         end
      endcase
   end

endmodule
